// File: rtl/psd_pkg.sv
// Shared types and default sizes for the programmable serial pattern detector.
package psd_pkg;

   localparam int unsigned MaxLenDef = 16;
   localparam int unsigned CntWDef   = 8;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StDetect
   } psd_state_e;

endpackage

// File: rtl/psd_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module psd_sat_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/psd_var.sv
// Serial pattern detector with run-time programmable length and overlap mode.
// History shifts in at the LSB; only the low len bits take part in the compare.
module psd_var
   import psd_pkg::*;
#(
   parameter int unsigned MAX_LEN = MaxLenDef,
   parameter int unsigned CNT_W   = CntWDef
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           load,
   input  logic [MAX_LEN-1:0]             pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   len,
   input  logic                           overlap,
   input  logic                           din,
   input  logic                           din_valid,
   output logic                           seen,
   output logic [CNT_W-1:0]               match_count,
   output logic                           armed
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] MinLen = LW'(2);
   localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

   psd_state_e         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LW-1:0]      fill_q, fill_d;
   logic               seen_q, seen_d;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_shift;
   logic [LW-1:0]      fill_inc;
   logic               match;
   logic               cnt_clr, cnt_inc;

   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         mask[i] = (i < int'(len_q));
      end
   end

   always_comb begin
      hist_shift = {hist_q[MAX_LEN-2:0], din};
      fill_inc   = (fill_q == len_q) ? fill_q : fill_q + 1'b1;
      match      = (fill_inc == len_q) && (((hist_shift ^ pat_q) & mask) == '0);
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      seen_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;

      if (load) begin
         pat_d   = pattern;
         len_d   = len;
         ovl_d   = overlap;
         hist_d  = '0;
         fill_d  = '0;
         cnt_clr = 1'b1;
         state_d = ((len >= MinLen) && (len <= MaxLen)) ? StFill : StIdle;
      end else if (din_valid && (state_q != StIdle)) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         if (match) begin
            seen_d  = 1'b1;
            cnt_inc = 1'b1;
            if (ovl_q) begin
               state_d = StDetect;
            end else begin
               // Non-overlapping: demand len fresh bits before the next compare.
               fill_d  = '0;
               state_d = StFill;
            end
         end else if (fill_inc == len_q) begin
            state_d = StDetect;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         seen_q  <= seen_d;
      end
   end

   psd_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .count  (match_count)
   );

   assign seen  = seen_q;
   assign armed = (state_q != StIdle);

endmodule

// File: tb/tb_psd_var.sv
// Scoreboard bench for psd_var: expected seen cycles are queued by the stimulus
// and retired by a monitor; a CNT_W=2 twin shares the stimulus for saturation.
module tb_psd_var;

   logic        clk = 1'b0;
   logic        resetn;
   logic        load;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic        overlap;
   logic        din;
   logic        din_valid;
   logic        seen0, seen1;
   logic [7:0]  count0;
   logic [1:0]  count1;
   logic        armed0, armed1;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   int unsigned exp_q[$];
   int unsigned e_cyc;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   psd_var #(
      .MAX_LEN (16),
      .CNT_W   (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .load        (load),
      .pattern     (pattern),
      .len         (len),
      .overlap     (overlap),
      .din         (din),
      .din_valid   (din_valid),
      .seen        (seen0),
      .match_count (count0),
      .armed       (armed0)
   );

   psd_var #(
      .MAX_LEN (16),
      .CNT_W   (2)
   ) dut_c2 (
      .clk         (clk),
      .resetn      (resetn),
      .load        (load),
      .pattern     (pattern),
      .len         (len),
      .overlap     (overlap),
      .din         (din),
      .din_valid   (din_valid),
      .seen        (seen1),
      .match_count (count1),
      .armed       (armed1)
   );

   // Monitor: every observed pulse must retire the oldest expected cycle.
   always @(negedge clk) begin
      if (seen0) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL seen_unexpected: seen=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e_cyc = exp_q.pop_front();
            if (e_cyc != cyc) begin
               fails++;
               $display("FAIL seen_cycle: pulse at cycle %0d, required cycle %0d", cyc, e_cyc);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      tests++;
      if (got != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         load      = 1'b0;
         din_valid = 1'b0;
      end
   endtask

   task automatic do_load(input logic [15:0] p, input logic [4:0] l, input logic o,
                          input logic dv, input logic d);
      @(negedge clk);
      load      = 1'b1;
      pattern   = p;
      len       = l;
      overlap   = o;
      din_valid = dv;
      din       = d;
      @(negedge clk);
      load      = 1'b0;
      din_valid = 1'b0;
   endtask

   // exp=1: this bit completes a match, so seen is due right after the next edge.
   task automatic send_bit(input logic b, input bit exp);
      @(negedge clk);
      load      = 1'b0;
      din       = b;
      din_valid = 1'b1;
      if (exp) exp_q.push_back(cyc + 1);
   endtask

   task automatic drain(input string name);
      idle(3);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      logic [15:0] wide;
      resetn    = 1'b0;
      load      = 1'b0;
      pattern   = '0;
      len       = '0;
      overlap   = 1'b0;
      din       = 1'b0;
      din_valid = 1'b0;
      idle(3);
      check("reset_armed", int'(armed0), 0);
      check("reset_count", int'(count0), 0);
      check("reset_seen", int'(seen0), 0);
      resetn = 1'b1;

      // Unprogrammed after reset: stays idle and ignores data.
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      drain("idle_unprog");
      check("idle_armed", int'(armed0), 0);

      // Overlapping, upper pattern bits are junk and must be ignored.
      do_load(16'hA5FB, 5'd5, 1'b1, 1'b0, 1'b0);
      check("ovl_armed", int'(armed0), 1);
      check("ovl_count0", int'(count0), 0);
      send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
      send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
      drain("ovl_pulses");
      check("ovl_count", int'(count0), 2);

      // Non-overlapping: same stream yields one match.
      do_load(16'h001B, 5'd5, 1'b0, 1'b0, 1'b0);
      check("novl_count0", int'(count0), 0);
      send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
      send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
      drain("novl_pulses");
      check("novl_count", int'(count0), 1);

      // Gaps in din_valid do not break a match.
      do_load(16'h001B, 5'd5, 1'b1, 1'b0, 1'b0);
      send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
      idle(3);
      send_bit(1, 1);
      drain("gap_pulses");
      check("gap_count", int'(count0), 1);

      // Data presented with load is discarded, so only four bits are collected.
      do_load(16'h001B, 5'd5, 1'b1, 1'b1, 1'b1);
      send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
      drain("load_prio_pulses");
      check("load_prio_count", int'(count0), 0);

      // Illegal lengths leave the block disarmed.
      do_load(16'h0001, 5'd1, 1'b1, 1'b0, 1'b0);
      check("len1_armed", int'(armed0), 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      drain("len1_pulses");
      check("len1_count", int'(count0), 0);
      do_load(16'hFFFF, 5'd17, 1'b1, 1'b0, 1'b0);
      check("len17_armed", int'(armed0), 0);
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
      drain("len17_pulses");

      // len=2 overlapping on all ones: match on every bit from the second.
      do_load(16'h0003, 5'd2, 1'b1, 1'b0, 1'b0);
      check("legal_armed", int'(armed0), 1);
      send_bit(1, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      drain("sat_pulses");
      check("sat_count_w8", int'(count0), 5);
      check("sat_count_w2", int'(count1), 3);

      // Full-width pattern, non-overlapping, sent twice.
      wide = 16'hA5C3;
      do_load(wide, 5'd16, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 15; i >= 0; i--) send_bit(wide[i], i == 0);
      end
      drain("full_pulses");
      check("full_count", int'(count0), 2);

      // Reset mid-sequence discards progress.
      do_load(16'h001B, 5'd5, 1'b1, 1'b0, 1'b0);
      send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
      @(negedge clk);
      din_valid = 1'b0;
      resetn    = 1'b0;
      #1;
      check("rst_async_armed", int'(armed0), 0);
      check("rst_async_count", int'(count1), 0);
      @(negedge clk);
      resetn = 1'b1;
      do_load(16'h001B, 5'd5, 1'b1, 1'b0, 1'b0);
      send_bit(1, 0);
      drain("rst_pulses");
      check("rst_count", int'(count0), 0);
      check("rst_armed", int'(armed0), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/psd_var.md
PSD_VAR -- requirements
Module: psd_var

Interface
REQ-001: Parameter MAX_LEN, default 16, is the maximum pattern length in bits (legal range 2..32).
REQ-002: Parameter CNT_W, default 8, is the match counter width in bits.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: resetn  input  1  asynchronous, active-low reset.
REQ-005: load  input  1  program strobe; samples pattern, len and overlap.
REQ-006: pattern  input  MAX_LEN  target sequence; pattern[len-1] is the first bit received, pattern[0] the last.
REQ-007: len  input  $clog2(MAX_LEN+1)  active pattern length.
REQ-008: overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009: din  input  1  serial data bit.
REQ-010: din_valid  input  1  din is sampled only when high.
REQ-011: seen  output  1  one-cycle match pulse.
REQ-012: match_count  output  CNT_W  saturating count of matches since the last load or reset.
REQ-013: armed  output  1  high while a legal pattern is programmed.

Function
REQ-014: The FSM shall have three states: IDLE (unprogrammed or illegal len), FILL (fewer than len valid bits collected), DETECT.
REQ-015: load=1 shall register pattern, len and overlap, clear the history shift register and fill count, clear match_count and go to FILL; if len<2 or len>MAX_LEN it shall go to IDLE instead.
REQ-016: load shall take priority over din_valid in the same cycle; that din bit shall be discarded.
REQ-017: Each din_valid=1 cycle outside IDLE shall shift din into the history LSB and increment the fill count, saturating at len.
REQ-018: FILL shall move to DETECT on the edge at which the fill count reaches len.
REQ-019: A match shall occur when the fill count equals len after the shift and history[len-1:0] equals pattern[len-1:0]; bits above len shall be ignored.
REQ-020: seen shall be registered and asserted for exactly one cycle, in the cycle following the edge that shifted in the completing bit.
REQ-021: seen shall stay low in any cycle with din_valid=0 or load=1.
REQ-022: With overlap=1, the history shall be kept after a match, so the next match may share bits.
REQ-023: With overlap=0, a match shall zero the fill count and return the FSM to FILL, so len fresh bits are needed.
REQ-024: match_count shall increment on each match and hold at 2^CNT_W-1.
REQ-025: armed shall be 1 in FILL and DETECT and 0 in IDLE; in IDLE, din shall be ignored and seen shall stay 0.
REQ-026: len==MAX_LEN shall be fully supported, with no index overflow.

Reset
REQ-027: While resetn=0, the block shall force seen=0, match_count=0, armed=0, history=0, fill count=0, stored pattern, len and overlap to 0, and state IDLE, asynchronously.
REQ-028: After resetn deasserts, the block shall stay in IDLE until the first load.
REQ-029: A reset mid-sequence shall discard all partial-match progress.

Structure
REQ-030: A shared package psd_pkg shall hold the state enum (IDLE, FILL, DETECT) and the MAX_LEN and CNT_W defaults.
REQ-031: The saturating match counter shall be a sub-module named psd_sat_cnt, parameterised by CNT_W, with clk, resetn, clr and inc ports.

Verification
REQ-032: Load pattern=5'b11011, len=5, overlap=1; stream 1,1,0,1,1,0,1,1 -> seen pulses after bits 5 and 8; match_count=2.
REQ-033: Same load with overlap=0 and the same stream -> seen pulses after bit 5 only; match_count=1.
REQ-034: Same load; stream 1,1,0,1 then din_valid=0 for 3 cycles, then 1 -> exactly one seen, one cycle after the final valid bit.
REQ-035: Load len=1, then len=MAX_LEN+1 -> armed=0 and no seen for any stream; then a legal load -> armed=1.
REQ-036: CNT_W=2, pattern 2'b11, len=2, overlap=1; 6 ones -> seen on bits 2..6 and match_count holding at 3.
REQ-037: Assert resetn=0 after 4 of 5 pattern bits, then reload and send 1 more bit -> no seen; match_count=0.
